// File: rtl/sdrd_pkg.sv
// Shared definitions for the SDRAM read sequencer: FSM encoding and fixed widths.
package sdrd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_REQ         = 2'd1,
        ST_DATA        = 2'd2,
        ST_ABORT_DRAIN = 2'd3
    } sdrd_state_e;

    localparam int SD_LEN_W = 5;
    localparam int DATA_W   = 16;

endpackage

// File: rtl/sdrd_fifo.sv
// Synchronous FIFO with flush; head word is read straight from the storage flops.
module sdrd_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LVL_W-1:0] level_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_q, rd_q;
    logic [LVL_W-1:0]            lvl_q;
    logic                        do_push, do_pop;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == LVL_W'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            lvl_q <= lvl_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign level_o = lvl_q;

endmodule

// File: rtl/sd_read_sequencer.sv
// Splits a host readout into SDRAM burst reads and buffers returned words in a FIFO.
// Optional SDRD_RING_WRAP_EN: addresses wrap inside [RING_BASE, RING_BASE+RING_WORDS).
module sd_read_sequencer
    import sdrd_pkg::*;
#(
    parameter int                ADDR_W     = 24,
    parameter int                LEN_W      = 10,
    parameter int                BURST      = 8,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RING_BASE  = '0,
    parameter logic [ADDR_W-1:0] RING_WORDS = 24'h800000
) (
    input  logic                clk,
    input  logic                cs_res,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [LEN_W-1:0]    start_len,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   sd_addr,
    output logic [SD_LEN_W-1:0] sd_len,
    output logic                sd_rd_req,
    input  logic                sd_rd_ack,
    input  logic                sd_rd_valid,
    input  logic [DATA_W-1:0]   sd_rd_data,
    input  logic                host_rd,
    output logic [DATA_W-1:0]   host_data,
    output logic                host_empty,
    output logic [SD_LEN_W-1:0] fifo_level
);

    localparam int CW    = ADDR_W + 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LW1   = LVL_W + 1;
`ifdef SDRD_RING_WRAP_EN
    localparam bit RING_EN = 1'b1;
`else
    localparam bit RING_EN = 1'b0;
`endif
    // Linear mode is the degenerate ring [0, 2^ADDR_W), so one datapath serves both.
    localparam logic [CW-1:0]     WRAP_END  = RING_EN ? ({1'b0, RING_BASE} + {1'b0, RING_WORDS})
                                                      : {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] WRAP_BASE = RING_EN ? RING_BASE : '0;

    sdrd_state_e           state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [SD_LEN_W-1:0]   beat_q, beat_d;
    logic                  done_q, done_d;

    logic [CW-1:0]         left, cand, next_sum;
    logic [ADDR_W-1:0]     next_addr, addr_start;
    logic [LEN_W-1:0]      rem_left;
    logic [SD_LEN_W-1:0]   blen;
    logic                  req_ok, last_beat;
    logic                  fifo_push, fifo_flush, fifo_full, fifo_empty;
    logic [LVL_W-1:0]      lvl;

    sdrd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (cs_res),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (sd_rd_data),
        .pop_i   (host_rd),
        .rdata_o (host_data),
        .level_o (lvl),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Burst sizing, address advance and credit check; addr_q/rem_q hold still
    // from REQ through the end of the burst, so blen is stable over that span.
    always_comb begin
        left = WRAP_END - {1'b0, addr_q};
        cand = CW'(BURST);
        if (CW'(rem_q) < cand) cand = CW'(rem_q);
        if (left < cand)       cand = left;
        blen      = SD_LEN_W'(cand);
        next_sum  = {1'b0, addr_q} + CW'(blen);
        next_addr = (next_sum == WRAP_END) ? WRAP_BASE : next_sum[ADDR_W-1:0];
        rem_left  = rem_q - LEN_W'(blen);
        req_ok    = (state_q == ST_REQ) && !fifo_full &&
                    (({1'b0, lvl} + LW1'(blen)) <= LW1'(FIFO_DEPTH));
        last_beat = sd_rd_valid && (beat_q == blen - SD_LEN_W'(1));
        addr_start = start_addr;
        if (RING_EN && ((start_addr < RING_BASE) || ({1'b0, start_addr} >= WRAP_END)))
            addr_start = RING_BASE;
    end

    always_ff @(posedge clk or negedge cs_res) begin
        if (!cs_res) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        beat_d     = beat_q;
        done_d     = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_len != '0) begin
                        addr_d     = addr_start;
                        rem_d      = start_len;
                        fifo_flush = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (req_ok && sd_rd_ack) begin
                    beat_d  = '0;
                    state_d = ST_DATA;
                end else if (abort) begin
                    done_d     = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (sd_rd_valid) beat_d = beat_q + SD_LEN_W'(1);
                if (abort) begin
                    if (last_beat) begin
                        done_d     = 1'b1;
                        fifo_flush = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_ABORT_DRAIN;
                    end
                end else begin
                    fifo_push = sd_rd_valid;
                    if (last_beat) begin
                        addr_d = next_addr;
                        rem_d  = rem_left;
                        if (rem_left == '0) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                end
            end
            ST_ABORT_DRAIN: begin
                if (sd_rd_valid) beat_d = beat_q + SD_LEN_W'(1);
                if (last_beat) begin
                    done_d     = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = done_q;
        sd_addr    = addr_q;
        sd_len     = (state_q == ST_IDLE) ? '0 : blen;
        sd_rd_req  = req_ok;
        host_empty = fifo_empty;
        fifo_level = SD_LEN_W'(lvl);
    end

endmodule

// File: tb/tb_sd_read_sequencer.sv
// Directed bench for sd_read_sequencer with a simple SDRAM controller responder.
`timescale 1ns/1ps
module tb_sd_read_sequencer;

    logic        clk = 1'b0;
    logic        cs_res, start, abort, sd_rd_ack, sd_rd_valid, host_rd;
    logic [23:0] start_addr, sd_addr;
    logic [9:0]  start_len;
    logic        busy, done, sd_rd_req, host_empty;
    logic [4:0]  sd_len, fifo_level;
    logic [15:0] sd_rd_data, host_data;

    int vectors = 0, miscompares = 0, done_cnt = 0;
    logic [23:0] cmd_addr[$];
    logic [4:0]  cmd_len[$];
    logic [15:0] got[$];

    always #5 clk = ~clk;

    sd_read_sequencer #(
        .ADDR_W(24), .LEN_W(10), .BURST(8), .FIFO_DEPTH(16)
`ifdef SDRD_RING_WRAP_EN
        , .RING_BASE(24'h0), .RING_WORDS(24'h400)
`endif
    ) dut (
        .clk(clk), .cs_res(cs_res), .start(start), .start_addr(start_addr),
        .start_len(start_len), .abort(abort), .busy(busy), .done(done),
        .sd_addr(sd_addr), .sd_len(sd_len), .sd_rd_req(sd_rd_req),
        .sd_rd_ack(sd_rd_ack), .sd_rd_valid(sd_rd_valid), .sd_rd_data(sd_rd_data),
        .host_rd(host_rd), .host_data(host_data), .host_empty(host_empty),
        .fifo_level(fifo_level)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Controller: acks two cycles after seeing req, then returns one beat per cycle.
    initial begin : ctrl
        logic [23:0] ca;
        logic [4:0]  cl;
        sd_rd_ack = 1'b0; sd_rd_valid = 1'b0; sd_rd_data = '0;
        forever begin
            @(negedge clk);
            sd_rd_ack = 1'b0;
            if (cs_res === 1'b1 && sd_rd_req === 1'b1) begin
                ca = sd_addr; cl = sd_len;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clk);
                    vectors++;
                    if (sd_rd_req !== 1'b1 || sd_addr !== ca || sd_len !== cl) begin
                        miscompares++;
                        $display("FAIL cmd_stable: got req=%b addr=%h len=%0d, expected req=1 addr=%h len=%0d",
                                 sd_rd_req, sd_addr, sd_len, ca, cl);
                    end
                end
                sd_rd_ack = 1'b1;
                cmd_addr.push_back(ca);
                cmd_len.push_back(cl);
                @(negedge clk);
                sd_rd_ack = 1'b0;
                for (int b = 0; b < int'(cl); b++) begin
                    if (cs_res !== 1'b1) break;
                    sd_rd_valid = 1'b1;
                    sd_rd_data  = ca[15:0] + 16'(b);
                    @(negedge clk);
                end
                sd_rd_valid = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [23:0] a, input logic [9:0] l);
        @(negedge clk);
        start_addr = a; start_len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pop_n(input int n, input int bound);
        int k = 0;
        for (int c = 0; c < bound && k < n; c++) begin
            @(negedge clk);
            if (host_empty === 1'b0) begin
                got.push_back(host_data);
                host_rd = 1'b1;
                k++;
            end else begin
                host_rd = 1'b0;
            end
        end
        @(negedge clk);
        host_rd = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        for (int c = 0; c < bound && done_cnt < target; c++) @(negedge clk);
    endtask

    task automatic clear_logs();
        cmd_addr.delete(); cmd_len.delete(); got.delete();
    endtask

    task automatic test_reset();
        cs_res = 1'b0; start = 1'b0; abort = 1'b0; host_rd = 1'b0;
        start_addr = '0; start_len = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, sd_rd_req, host_empty} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_flags: got busy/done/req/empty=%b expected 0001",
                     {busy, done, sd_rd_req, host_empty});
        end
        vectors++;
        if (sd_addr !== 24'h0 || sd_len !== 5'd0 || fifo_level !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_values: got addr=%h len=%0d level=%0d expected 0/0/0",
                     sd_addr, sd_len, fifo_level);
        end
        cs_res = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        logic [23:0] ea [3];
        logic [4:0]  el [3];
        ea = '{24'h100, 24'h108, 24'h110};
        el = '{5'd8, 5'd8, 5'd4};
        clear_logs();
        do_start(24'h000100, 10'd20);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL basic_busy: got %b expected 1", busy);
        end
        pop_n(20, 400);
        wait_done(d0 + 1, 50);
        repeat (5) @(negedge clk);
        vectors++;
        if (cmd_addr.size() !== 3) begin
            miscompares++; $display("FAIL basic_ncmd: got %0d expected 3", cmd_addr.size());
        end
        for (int i = 0; i < 3 && i < cmd_addr.size(); i++) begin
            vectors++;
            if (cmd_addr[i] !== ea[i] || cmd_len[i] !== el[i]) begin
                miscompares++;
                $display("FAIL basic_cmd%0d: got (%h,%0d) expected (%h,%0d)",
                         i, cmd_addr[i], cmd_len[i], ea[i], el[i]);
            end
        end
        vectors++;
        if (got.size() !== 20) begin
            miscompares++; $display("FAIL basic_nwords: got %0d expected 20", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== 16'h0100 + 16'(i)) begin
                miscompares++;
                $display("FAIL basic_data%0d: got %h expected %h", i, got[i], 16'h0100 + 16'(i));
            end
        end
        vectors++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0 || host_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_end: got dones=%0d busy=%b empty=%b expected 1/0/1",
                     done_cnt - d0, busy, host_empty);
        end
    endtask

    task automatic test_credit();
        int d0 = done_cnt;
        clear_logs();
        do_start(24'h000200, 10'd20);
        repeat (60) @(negedge clk);
        vectors++;
        if (cmd_addr.size() !== 2 || sd_rd_req !== 1'b0 || fifo_level !== 5'd16 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_full: got ncmd=%0d req=%b level=%0d busy=%b expected 2/0/16/1",
                     cmd_addr.size(), sd_rd_req, fifo_level, busy);
        end
        pop_n(3, 10);
        vectors++;
        if (sd_rd_req !== 1'b0 || fifo_level !== 5'd13) begin
            miscompares++;
            $display("FAIL credit_13: got req=%b level=%0d expected 0/13", sd_rd_req, fifo_level);
        end
        pop_n(1, 10);
        vectors++;
        if (sd_rd_req !== 1'b1 || fifo_level !== 5'd12) begin
            miscompares++;
            $display("FAIL credit_12: got req=%b level=%0d expected 1/12", sd_rd_req, fifo_level);
        end
        pop_n(16, 300);
        wait_done(d0 + 1, 50);
        repeat (3) @(negedge clk);
        vectors++;
        if (cmd_addr.size() !== 3 || (cmd_addr.size() == 3 && (cmd_addr[2] !== 24'h210 || cmd_len[2] !== 5'd4))) begin
            miscompares++;
            $display("FAIL credit_cmd3: got ncmd=%0d, expected 3 with last (000210,4)", cmd_addr.size());
        end
        vectors++;
        if (got.size() !== 20) begin
            miscompares++; $display("FAIL credit_nwords: got %0d expected 20", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== 16'h0200 + 16'(i)) begin
                miscompares++;
                $display("FAIL credit_data%0d: got %h expected %h", i, got[i], 16'h0200 + 16'(i));
            end
        end
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++; $display("FAIL credit_done: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_empty();
        int d0 = done_cnt;
        logic saw_req = 1'b0;
        clear_logs();
        do_start(24'h000123, 10'd0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_done: got done=%b busy=%b expected 1/0", done, busy);
        end
        repeat (10) begin
            @(negedge clk);
            if (sd_rd_req === 1'b1 || busy === 1'b1) saw_req = 1'b1;
        end
        vectors++;
        if (saw_req !== 1'b0 || cmd_addr.size() !== 0 || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL empty_quiet: got req_or_busy=%b ncmd=%0d dones=%0d expected 0/0/1",
                     saw_req, cmd_addr.size(), done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        logic hit = 1'b0;
        clear_logs();
        do_start(24'h000300, 10'd20);
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (fifo_level === 5'd3) hit = 1'b1;
        end
        abort = 1'b1;
        vectors++;
        if (hit !== 1'b1) begin
            miscompares++; $display("FAIL abort_reach3: got level=%0d expected 3", fifo_level);
        end
        @(negedge clk);
        vectors++;
        if (fifo_level !== 5'd3 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_discard: got level=%0d busy=%b expected 3/1", fifo_level, busy);
        end
        wait_done(d0 + 1, 60);
        @(negedge clk);
        abort = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (host_empty !== 1'b1 || fifo_level !== 5'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_flush: got empty=%b level=%0d busy=%b expected 1/0/0",
                     host_empty, fifo_level, busy);
        end
        vectors++;
        if (done_cnt - d0 !== 1 || cmd_addr.size() !== 1) begin
            miscompares++;
            $display("FAIL abort_once: got dones=%0d ncmd=%0d expected 1/1", done_cnt - d0, cmd_addr.size());
        end
    endtask

    task automatic test_wrap();
        int d0 = done_cnt;
        logic [23:0] a0;
        logic [15:0] exp;
`ifdef SDRD_RING_WRAP_EN
        a0 = 24'h0003FC;
`else
        a0 = 24'hFFFFFC;
`endif
        clear_logs();
        do_start(a0, 10'd8);
        pop_n(8, 200);
        wait_done(d0 + 1, 50);
        repeat (3) @(negedge clk);
        vectors++;
        if (cmd_addr.size() !== 2) begin
            miscompares++; $display("FAIL wrap_ncmd: got %0d expected 2", cmd_addr.size());
        end else begin
            vectors++;
            if (cmd_addr[0] !== a0 || cmd_len[0] !== 5'd4 || cmd_addr[1] !== 24'h0 || cmd_len[1] !== 5'd4) begin
                miscompares++;
                $display("FAIL wrap_cmds: got (%h,%0d),(%h,%0d) expected (%h,4),(000000,4)",
                         cmd_addr[0], cmd_len[0], cmd_addr[1], cmd_len[1], a0);
            end
        end
        vectors++;
        if (got.size() !== 8 || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL wrap_count: got words=%0d dones=%0d expected 8/1", got.size(), done_cnt - d0);
        end
        for (int i = 0; i < got.size(); i++) begin
            exp = (i < 4) ? a0[15:0] + 16'(i) : 16'(i - 4);
            vectors++;
            if (got[i] !== exp) begin
                miscompares++; $display("FAIL wrap_data%0d: got %h expected %h", i, got[i], exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        logic hit = 1'b0;
        clear_logs();
        do_start(24'h000040, 10'd8);
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (fifo_level === 5'd2) hit = 1'b1;
        end
        cs_res = 1'b0;
        #1;
        vectors++;
        if (hit !== 1'b1 || {busy, done, sd_rd_req, host_empty} !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstmid_flags: got hit=%b busy/done/req/empty=%b expected 1, 0001",
                     hit, {busy, done, sd_rd_req, host_empty});
        end
        vectors++;
        if (sd_addr !== 24'h0 || sd_len !== 5'd0 || fifo_level !== 5'd0) begin
            miscompares++;
            $display("FAIL rstmid_values: got addr=%h len=%0d level=%0d expected 0/0/0",
                     sd_addr, sd_len, fifo_level);
        end
        repeat (3) @(negedge clk);
        cs_res = 1'b1;
        repeat (5) @(negedge clk);
        clear_logs();
        do_start(24'h000050, 10'd4);
        pop_n(4, 200);
        wait_done(d0 + 1, 50);
        repeat (3) @(negedge clk);
        vectors++;
        if (cmd_addr.size() !== 1 || (cmd_addr.size() == 1 && (cmd_addr[0] !== 24'h50 || cmd_len[0] !== 5'd4))) begin
            miscompares++;
            $display("FAIL rstmid_cmd: got ncmd=%0d expected 1 command (000050,4)", cmd_addr.size());
        end
        vectors++;
        if (got.size() !== 4 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_after: got words=%0d dones=%0d busy=%b expected 4/1/0",
                     got.size(), done_cnt - d0, busy);
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== 16'h0050 + 16'(i)) begin
                miscompares++;
                $display("FAIL rstmid_data%0d: got %h expected %h", i, got[i], 16'h0050 + 16'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit();
        test_empty();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
